dac_spi_frame_gen: RTL and testbench
====================================

Name: dac_spi_frame_gen

Overview:
- Upstream SPI frame generator for the DAC serializer stage. Drives cs, sck, cnt_sck and data_sdi into the serializer, which emits sdi and ldac.
- Accepts one 16-bit DAC code per start request when key_state is high.
- Produces one 16-bit frame, then holds cs high with cnt_sck==16 long enough for the serializer's ldac pulse to complete.
- Reports busy and done back to the training-control FSM.

Parameters:
- SCK_DIV, 2: clk cycles per sck half-period. Must be ≥2 so registered sdi settles before the sck rising edge.
- CS_SETUP, 2: clk cycles cs is low with sck low before the first sck period.
- CS_HOLD, 2: clk cycles cs stays low after the 16th sck falling edge.
- LDAC_WAIT, 16: clk cycles cs is high with cnt_sck==16 before done. Must be ≥14 to cover the 5-cycle tLS plus the 8-cycle tLD window.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_state  in  1  run enable; low aborts and idles the block
- start  in  1  one-cycle request; sampled only in IDLE
- data_in  in  16  DAC code; sampled with start
- data_sdi  out  16  latched code to the serializer; held until the next accepted start
- en_dac  out  1  one-cycle pulse in the cycle after start is accepted
- cs  out  1  chip select, active low
- sck  out  1  serial clock, idle low
- cnt_sck  out  5  bits completed in this frame, 0..16
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- All outputs are registered. Every output is driven only by this block's registers.
- Reset values: cs=1, sck=0, cnt_sck=0, data_sdi=0, en_dac=0, busy=0, done=0, state=IDLE.
- States: IDLE, SETUP, SHIFT, HOLD, LDAC, DONE.
- Timing below counts cycle 0 as the cycle where start=1 and key_state=1 are sampled in IDLE. All numbers use default parameters.
- IDLE:
  - cs=1, sck=0, cnt_sck=0, busy=0.
  - On start&key_state: latch data_in into data_sdi, go to SETUP.
  - Cycle 1 shows cs=0, busy=1, en_dac=1.
- SETUP:
  - Lasts CS_SETUP cycles (cycles 1–2). cs=0, sck=0, cnt_sck=0.
- SHIFT:
  - 16 sck periods. Period k (0..15) has SCK_DIV low cycles, then SCK_DIV high cycles.
  - With defaults, sck is high on cycles 5+4k and 6+4k.
  - In the cycle sck returns low, cnt_sck increments to k+1.
  - cnt_sck reaches 16 at cycle 67; go to HOLD.
- HOLD:
  - Lasts CS_HOLD cycles (67–68). cs=0, sck=0, cnt_sck=16.
- LDAC:
  - Lasts LDAC_WAIT cycles. cs=1, sck=0, cnt_sck=16 (cycles 69–84).
- DONE:
  - Cycle 85: done=1, busy=0, cnt_sck=0, cs=1. Return to IDLE.
  - A start at cycle 85 is accepted.
  - Frame period is 1 + CS_SETUP + 32·SCK_DIV + CS_HOLD + LDAC_WAIT cycles.
- start while busy: ignored. No queuing, and data_sdi is unchanged.
- key_state low in any state: next cycle goes to IDLE with cs=1, sck=0, cnt_sck=0, busy=0, and no done.
  - data_sdi keeps its value.
  - start together with key_state=0 is not accepted.
- Counters:
  - The phase counter is sized to clog2(max(SCK_DIV, CS_SETUP, CS_HOLD, LDAC_WAIT)+1).
  - The phase counter clears on every state change.
  - cnt_sck saturates at 16 and never wraps.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package (dac_pkg):
  - State encoding constants.
  - DAC_BITS=16.
  - CNT_SCK_W=5.
  - Default timing constants, shared with the serializer (tLS count 4, tLD count 7).
- One sub-module is natural: dac_sck_div. It is a half-period divider that emits a sck level, a fall pulse, and a phase-done pulse. It is instanced in SHIFT and reused for the SETUP, HOLD and LDAC waits.

Test Plan:
- Single frame:
  - Stimulus: key_state=1; start with data_in=16'hA5C3 at cycle 0.
  - Response: cs falls at cycle 1; 16 sck rising edges at cycles 5, 9, …, 65.
  - With the serializer attached, sdi sampled on the rising edges reads A5C3 MSB-first.
  - cs rises at cycle 69; ldac low for 8 cycles inside 69–84; done=1 at cycle 85.
- Back-to-back:
  - Stimulus: start 16'h0001 at cycle 0 and 16'hFFFF at cycle 85.
  - Response: second cs fall at cycle 86; data_sdi=FFFF from cycle 86.
- Start while busy:
  - Stimulus: start with 16'h1234 at cycle 30 during the frame.
  - Response: ignored; data_sdi, cnt_sck and frame timing are unchanged.
- Abort:
  - Stimulus: key_state=0 at cycle 40.
  - Response: at cycle 41 cs=1, sck=0, cnt_sck=0, busy=0; done is never asserted.
  - A new start after key_state=1 produces a full normal frame.
- Reset mid-frame:
  - Stimulus: rst_n=0 at cycle 50.
  - Response: outputs go to reset values in the same cycle; the first frame after reset is normal.
- Parameter sweep:
  - Stimulus: SCK_DIV=4, CS_SETUP=3, LDAC_WAIT=20.
  - Response: sck high 4 cycles per period; done at cycle 1+3+128+2+20=154.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC SPI frame generator and serializer.
package dac_pkg;

  localparam int DAC_BITS  = 16;
  localparam int CNT_SCK_W = 5;

  // Default frame timing, in clk cycles.
  localparam int DEF_SCK_DIV   = 2;
  localparam int DEF_CS_SETUP  = 2;
  localparam int DEF_CS_HOLD   = 2;
  localparam int DEF_LDAC_WAIT = 16;

  // Serializer-side ldac timing: tLS delay count and tLD low-pulse count.
  localparam int T_LS_CNT = 4;
  localparam int T_LD_CNT = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LDAC  = 3'd4,
    ST_DONE  = 3'd5
  } dac_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dac_sck_div.sv
// Phase counter / half-period divider. Counts len cycles per phase; when
// toggling is enabled it flips the sck level at each phase end and flags
// the falling edge. A clear restarts the phase with sck low.
module dac_sck_div #(
  parameter int PH_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            toggle_en,
  input  logic [PH_W-1:0] len,
  output logic            sck_lvl,
  output logic            sck_fall,
  output logic            ph_done
);

  logic [PH_W-1:0] ph;

  // Phase end and sck falling-edge flags for the current cycle.
  always_comb begin
    ph_done  = (ph == len - PH_W'(1));
    sck_fall = ph_done && toggle_en && sck_lvl;
  end

  // Phase counter and sck level; a clear forces both back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= '0;
      sck_lvl <= 1'b0;
    end else if (clr) begin
      ph      <= '0;
      sck_lvl <= 1'b0;
    end else if (ph_done) begin
      ph <= '0;
      if (toggle_en) sck_lvl <= ~sck_lvl;
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_frame_gen.sv
// SPI frame generator feeding the DAC serializer: one 16-bit frame per
// accepted start, followed by a cs-high window long enough for ldac.
module dac_spi_frame_gen
  import dac_pkg::*;
#(
  parameter int SCK_DIV   = DEF_SCK_DIV,
  parameter int CS_SETUP  = DEF_CS_SETUP,
  parameter int CS_HOLD   = DEF_CS_HOLD,
  parameter int LDAC_WAIT = DEF_LDAC_WAIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_state,
  input  logic                 start,
  input  logic [DAC_BITS-1:0]  data_in,
  output logic [DAC_BITS-1:0]  data_sdi,
  output logic                 en_dac,
  output logic                 cs,
  output logic                 sck,
  output logic [CNT_SCK_W-1:0] cnt_sck,
  output logic                 busy,
  output logic                 done
);

  localparam int PH_W = $clog2(max4(SCK_DIV, CS_SETUP, CS_HOLD, LDAC_WAIT) + 1);
  localparam logic [CNT_SCK_W-1:0] CNT_LAST = CNT_SCK_W'(DAC_BITS - 1);
  localparam logic [CNT_SCK_W-1:0] CNT_FULL = CNT_SCK_W'(DAC_BITS);

  dac_state_t           state, state_nxt;
  logic [PH_W-1:0]      ph_len;
  logic                 ph_clr, ph_done, sck_fall, sck_lvl;
  logic                 accept;
  logic                 cs_nxt, busy_nxt, done_nxt;
  logic [CNT_SCK_W-1:0] cnt_nxt;

  dac_sck_div #(.PH_W(PH_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ph_clr),
    .toggle_en (state == ST_SHIFT),
    .len       (ph_len),
    .sck_lvl   (sck_lvl),
    .sck_fall  (sck_fall),
    .ph_done   (ph_done)
  );

  assign sck = sck_lvl;

  // Next-state decode plus the values the output registers take next cycle.
  always_comb begin
    state_nxt = state;
    ph_len    = PH_W'(1);
    accept    = key_state && start && (state == ST_IDLE || state == ST_DONE);

    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: begin
        ph_len = PH_W'(CS_SETUP);
        if (ph_done) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ph_len = PH_W'(SCK_DIV);
        if (sck_fall && cnt_sck == CNT_LAST) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        ph_len = PH_W'(CS_HOLD);
        if (ph_done) state_nxt = ST_LDAC;
      end
      ST_LDAC: begin
        ph_len = PH_W'(LDAC_WAIT);
        if (ph_done) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = accept ? ST_SETUP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Dropping the run enable wins over every transition.
    if (!key_state) state_nxt = ST_IDLE;

    ph_clr   = (state_nxt != state);
    cs_nxt   = !(state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    busy_nxt = state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD, ST_LDAC};
    done_nxt = (state_nxt == ST_DONE);

    // Bit count holds through HOLD/LDAC and saturates at a full frame.
    if (!(state_nxt inside {ST_SHIFT, ST_HOLD, ST_LDAC}))
      cnt_nxt = '0;
    else if (state == ST_SHIFT && sck_fall && cnt_sck != CNT_FULL)
      cnt_nxt = cnt_sck + CNT_SCK_W'(1);
    else
      cnt_nxt = cnt_sck;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Registered outputs; the code is latched only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs       <= 1'b1;
      cnt_sck  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_dac   <= 1'b0;
      data_sdi <= '0;
    end else begin
      cs      <= cs_nxt;
      cnt_sck <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      en_dac  <= accept;
      if (accept) data_sdi <= data_in;
    end
  end

endmodule

// File: tb/tb_dac_spi_frame_gen.sv
// Directed bench for dac_spi_frame_gen: default-parameter instance plus a
// second instance with stretched timing.
module tb_dac_spi_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_state, start;
  logic [15:0] data_in, data_sdi;
  logic        en_dac, cs, sck, busy, done;
  logic [4:0]  cnt_sck;

  logic        key_state2, start2;
  logic [15:0] data_in2, data_sdi2;
  logic        en_dac2, cs2, sck2, busy2, done2;
  logic [4:0]  cnt_sck2;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       cs;
    logic       sck;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
    logic       en_dac;
  } exp_t;

  always #5 clk = ~clk;

  dac_spi_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(start),
    .data_in(data_in), .data_sdi(data_sdi), .en_dac(en_dac), .cs(cs),
    .sck(sck), .cnt_sck(cnt_sck), .busy(busy), .done(done)
  );

  dac_spi_frame_gen #(.SCK_DIV(4), .CS_SETUP(3), .CS_HOLD(2), .LDAC_WAIT(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_state(key_state2), .start(start2),
    .data_in(data_in2), .data_sdi(data_sdi2), .en_dac(en_dac2), .cs(cs2),
    .sck(sck2), .cnt_sck(cnt_sck2), .busy(busy2), .done(done2)
  );

  // Expected outputs in cycle n of a frame whose start was sampled in cycle 0.
  function automatic exp_t exp_at(input int n, input int sd, input int su,
                                  input int ho, input int lw);
    exp_t e;
    int s0, h0, l0, d0, m;
    e = '0;
    e.cs = 1'b1;
    s0 = su + 1;
    h0 = s0 + 32 * sd;
    l0 = h0 + ho;
    d0 = l0 + lw;
    if (n >= 1 && n < s0) begin
      e.cs = 1'b0; e.busy = 1'b1; e.en_dac = (n == 1);
    end else if (n >= s0 && n < h0) begin
      m = n - s0;
      e.cs = 1'b0; e.busy = 1'b1;
      e.sck = ((m % (2 * sd)) >= sd);
      e.cnt = 5'(m / (2 * sd));
    end else if (n >= h0 && n < l0) begin
      e.cs = 1'b0; e.busy = 1'b1; e.cnt = 5'd16;
    end else if (n >= l0 && n < d0) begin
      e.busy = 1'b1; e.cnt = 5'd16;
    end else if (n == d0) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t obs1();
    return {cs, sck, cnt_sck, busy, done, en_dac};
  endfunction

  function automatic exp_t obs2();
    return {cs2, sck2, cnt_sck2, busy2, done2, en_dac2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_state = 1'b1; start = 1'b0; data_in = 16'h0;
    key_state2 = 1'b1; start2 = 1'b0; data_in2 = 16'h0;
    tick(); tick();
    n_total++;
    if ({obs1(), data_sdi} !== {exp_at(0, 2, 2, 2, 16), 16'h0}) begin
      $display("FAIL reset_dut got=%b/%h exp=%b/0000", obs1(), data_sdi, exp_at(0, 2, 2, 2, 16));
    end else n_pass++;
    n_total++;
    if ({obs2(), data_sdi2} !== {exp_at(0, 4, 3, 2, 20), 16'h0}) begin
      $display("FAIL reset_dut2 got=%b/%h exp=%b/0000", obs2(), data_sdi2, exp_at(0, 4, 3, 2, 20));
    end else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    exp_t e;
    data_in = 16'hA5C3; start = 1'b1;
    tick();
    start = 1'b0; data_in = 16'h0;
    for (int n = 1; n <= 87; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if (obs1() !== e) $display("FAIL single cyc=%0d got=%b exp=%b", n, obs1(), e);
      else n_pass++;
      n_total++;
      if (data_sdi !== 16'hA5C3) $display("FAIL single_data cyc=%0d got=%h exp=a5c3", n, data_sdi);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] d;
    int m;
    data_in = 16'h0001; start = 1'b1;
    tick();
    for (int n = 1; n <= 171; n++) begin
      m = (n <= 85) ? n : n - 85;
      d = (n <= 85) ? 16'h0001 : 16'hFFFF;
      e = exp_at(m, 2, 2, 2, 16);
      n_total++;
      if (obs1() !== e) $display("FAIL b2b cyc=%0d got=%b exp=%b", n, obs1(), e);
      else n_pass++;
      n_total++;
      if (data_sdi !== d) $display("FAIL b2b_data cyc=%0d got=%h exp=%h", n, data_sdi, d);
      else n_pass++;
      if (n == 85) begin data_in = 16'hFFFF; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    data_in = 16'h00F0; start = 1'b1;
    tick();
    for (int n = 1; n <= 86; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if (obs1() !== e) $display("FAIL busy_start cyc=%0d got=%b exp=%b", n, obs1(), e);
      else n_pass++;
      n_total++;
      if (data_sdi !== 16'h00F0) $display("FAIL busy_start_data cyc=%0d got=%h exp=00f0", n, data_sdi);
      else n_pass++;
      if (n == 30) begin data_in = 16'h1234; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int done_seen;
    data_in = 16'h5A5A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if (obs1() !== e) $display("FAIL abort_pre cyc=%0d got=%b exp=%b", n, obs1(), e);
      else n_pass++;
      if (n < 40) tick();
    end
    key_state = 1'b0;
    tick();
    n_total++;
    if ({obs1(), data_sdi} !== {exp_at(0, 2, 2, 2, 16), 16'h5A5A})
      $display("FAIL abort_idle got=%b/%h exp=%b/5a5a", obs1(), data_sdi, exp_at(0, 2, 2, 2, 16));
    else n_pass++;
    data_in = 16'hBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({obs1(), data_sdi} !== {exp_at(0, 2, 2, 2, 16), 16'h5A5A})
      $display("FAIL abort_nokey_start got=%b/%h exp=%b/5a5a", obs1(), data_sdi, exp_at(0, 2, 2, 2, 16));
    else n_pass++;
    done_seen = 0;
    for (int n = 0; n < 100; n++) begin
      if (done || busy) done_seen++;
      tick();
    end
    n_total++;
    if (done_seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    else n_pass++;
    key_state = 1'b1;
    tick();
    data_in = 16'h3C3C; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 86; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if ({obs1(), data_sdi} !== {e, 16'h3C3C})
        $display("FAIL abort_refrm cyc=%0d got=%b/%h exp=%b/3c3c", n, obs1(), data_sdi, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    data_in = 16'h7777; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if (obs1() !== e) $display("FAIL rst_pre cyc=%0d got=%b exp=%b", n, obs1(), e);
      else n_pass++;
      if (n < 50) tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({obs1(), data_sdi} !== {exp_at(0, 2, 2, 2, 16), 16'h0})
      $display("FAIL rst_async got=%b/%h exp=%b/0000", obs1(), data_sdi, exp_at(0, 2, 2, 2, 16));
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    data_in = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 86; n++) begin
      e = exp_at(n, 2, 2, 2, 16);
      n_total++;
      if ({obs1(), data_sdi} !== {e, 16'h1111})
        $display("FAIL rst_post cyc=%0d got=%b/%h exp=%b/1111", n, obs1(), data_sdi, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_param_sweep();
    exp_t e;
    data_in2 = 16'hC0DE; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 156; n++) begin
      e = exp_at(n, 4, 3, 2, 20);
      n_total++;
      if ({obs2(), data_sdi2} !== {e, 16'hC0DE})
        $display("FAIL sweep cyc=%0d got=%b/%h exp=%b/c0de", n, obs2(), data_sdi2, e);
      else n_pass++;
      if (n == 154) begin
        n_total++;
        if (done2 !== 1'b1) $display("FAIL sweep_done154 got=%b exp=1", done2);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_reset_mid_frame();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
